// File: rtl/alu_host.sv
// Command/response host for a multi-cycle ALU. It sends operand A and then operand B on a
// shared bus, waits for completion or a timeout, and returns the captured result and flags.
module alu_host #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        alu_start,
    output logic [3:0]  alu_s,
    output logic [15:0] alu_inbus,
    input  logic [15:0] alu_outbus,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_finish
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_OPB, S_WAIT, S_CAPT, S_RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [15:0] a_q, b_q;
    logic [7:0]  wait_cnt;
    logic        timeout_hit;

    // A finish arriving in the last allowed WAIT cycle still counts as normal completion.
    assign timeout_hit = (state == S_WAIT) && !alu_finish && (wait_cnt == TIMEOUT_LAST);

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_START;
            S_START: state_nxt = S_OPB;
            S_OPB:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (alu_finish)       state_nxt = S_CAPT;
                else if (timeout_hit) state_nxt = S_RESP;
            end
            S_CAPT:  state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from registers only, so no path runs from the ALU inputs to an output.
    always_comb begin
        cmd_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        alu_start = (state == S_START);
        alu_s     = (state == S_IDLE) ? 4'h0 : op_q;
        case (state)
            S_START: alu_inbus = a_q;
            S_OPB:   alu_inbus = b_q;
            default: alu_inbus = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wait_cnt  <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                op_q <= cmd_op;
                a_q  <= cmd_a;
                b_q  <= cmd_b;
            end

            if (state != S_WAIT)  wait_cnt <= '0;
            else if (!alu_finish) wait_cnt <= wait_cnt + 8'd1;

            if (state == S_WAIT && alu_finish)
                rsp_flags <= {alu_negative, alu_zero, alu_carry, alu_overflow};

            if (timeout_hit) begin
                rsp_data  <= '0;
                rsp_flags <= '0;
                rsp_err   <= 1'b1;
            end

            // The ALU result register is valid one cycle after its finish pulse.
            if (state == S_CAPT) begin
                rsp_data <= alu_outbus;
                rsp_err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_host.sv
// Self-checking bench for alu_host: a table of directed transactions, a mid-WAIT reset
// sequence and randomized transactions, all checked against a transaction-level model.
module tb_alu_host;
    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic        rsp_ready = 1'b0;
    logic [15:0] alu_outbus = '0;
    logic [3:0]  alu_flg = '0;
    logic        alu_finish = 1'b0;
    bit          use4 = 1'b0;

    logic        r8_cmd_ready, r8_rsp_valid, r8_rsp_err, r8_alu_start;
    logic [15:0] r8_rsp_data, r8_alu_inbus;
    logic [3:0]  r8_rsp_flags, r8_alu_s;
    logic        r4_cmd_ready, r4_rsp_valid, r4_rsp_err, r4_alu_start;
    logic [15:0] r4_rsp_data, r4_alu_inbus;
    logic [3:0]  r4_rsp_flags, r4_alu_s;

    logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_alu_start;
    logic [15:0] o_rsp_data, o_alu_inbus;
    logic [3:0]  o_rsp_flags, o_alu_s;

    int n_checks = 0;
    int n_err    = 0;
    int txn_id   = 0;

    always #5 clk = ~clk;

    alu_host #(.TIMEOUT_CYC(8)) u_dut8 (
        .clk(clk), .rst_b(rst_b), .cmd_valid(cmd_valid), .cmd_ready(r8_cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(r8_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(r8_rsp_data), .rsp_flags(r8_rsp_flags),
        .rsp_err(r8_rsp_err), .alu_start(r8_alu_start), .alu_s(r8_alu_s),
        .alu_inbus(r8_alu_inbus), .alu_outbus(alu_outbus), .alu_negative(alu_flg[3]),
        .alu_zero(alu_flg[2]), .alu_carry(alu_flg[1]), .alu_overflow(alu_flg[0]),
        .alu_finish(alu_finish)
    );

    alu_host #(.TIMEOUT_CYC(4)) u_dut4 (
        .clk(clk), .rst_b(rst_b), .cmd_valid(cmd_valid), .cmd_ready(r4_cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(r4_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(r4_rsp_data), .rsp_flags(r4_rsp_flags),
        .rsp_err(r4_rsp_err), .alu_start(r4_alu_start), .alu_s(r4_alu_s),
        .alu_inbus(r4_alu_inbus), .alu_outbus(alu_outbus), .alu_negative(alu_flg[3]),
        .alu_zero(alu_flg[2]), .alu_carry(alu_flg[1]), .alu_overflow(alu_flg[0]),
        .alu_finish(alu_finish)
    );

    assign o_cmd_ready = use4 ? r4_cmd_ready : r8_cmd_ready;
    assign o_rsp_valid = use4 ? r4_rsp_valid : r8_rsp_valid;
    assign o_rsp_err   = use4 ? r4_rsp_err   : r8_rsp_err;
    assign o_alu_start = use4 ? r4_alu_start : r8_alu_start;
    assign o_rsp_data  = use4 ? r4_rsp_data  : r8_rsp_data;
    assign o_alu_inbus = use4 ? r4_alu_inbus : r8_alu_inbus;
    assign o_rsp_flags = use4 ? r4_rsp_flags : r8_rsp_flags;
    assign o_alu_s     = use4 ? r4_alu_s     : r8_alu_s;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          k;      // WAIT cycle (1-based) carrying alu_finish; 0 = never
        logic [15:0] outv;
        logic [3:0]  flg;
        int          bp;     // extra RESP cycles with rsp_ready low
        bit          use4;
        logic [15:0] exp_data;
        logic [3:0]  exp_flags;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (txn %0d): got 0x%0h expected 0x%0h", name, txn_id, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input int k, input logic [15:0] outv, input logic [3:0] flg,
                                input int bp, input bit u4, input logic [15:0] ed,
                                input logic [3:0] ef, input logic ee);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.k = k; v.outv = outv; v.flg = flg; v.bp = bp;
        v.use4 = u4; v.exp_data = ed; v.exp_flags = ef; v.exp_err = ee;
        return v;
    endfunction

    // Transaction-level reference: the ALU result wins if its finish lands within the timeout window.
    function automatic vec_t model(input vec_t v);
        int t;
        bit fin;
        t   = v.use4 ? 4 : 8;
        fin = (v.k >= 1) && (v.k <= t);
        v.exp_data  = fin ? v.outv : 16'h0000;
        v.exp_flags = fin ? v.flg : 4'h0;
        v.exp_err   = !fin;
        return v;
    endfunction

    // Cycle (counted from the accept edge) in which rsp_valid is first seen.
    function automatic int resp_cycle(input int k, input int t);
        return (k >= 1 && k <= t) ? k + 4 : t + 3;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cmd_ready"}, 32'(o_cmd_ready), 32'd1);
        check({tag, ".rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        check({tag, ".rsp_data"},  32'(o_rsp_data),  32'd0);
        check({tag, ".rsp_flags"}, 32'(o_rsp_flags), 32'd0);
        check({tag, ".rsp_err"},   32'(o_rsp_err),   32'd0);
        check({tag, ".alu_start"}, 32'(o_alu_start), 32'd0);
        check({tag, ".alu_s"},     32'(o_alu_s),     32'd0);
        check({tag, ".alu_inbus"}, 32'(o_alu_inbus), 32'd0);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; rsp_ready = 1'b0; alu_finish = 1'b0;
        rst_b = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_txn(input vec_t v);
        int  t, rc, last, wc;
        bit  fin, in_wait;
        txn_id++;
        t    = v.use4 ? 4 : 8;
        fin  = (v.k >= 1) && (v.k <= t);
        rc   = resp_cycle(v.k, t);
        last = rc + v.bp;
        wc   = fin ? v.k : t;
        check("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
        cmd_valid  = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
        rsp_ready  = 1'(($urandom));
        alu_finish = 1'($urandom);
        alu_flg    = 4'($urandom);
        alu_outbus = 16'($urandom);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            check("cmd_ready_busy", 32'(o_cmd_ready), 32'd0);
            check("alu_start", 32'(o_alu_start), 32'(c == 1));
            check("alu_s", 32'(o_alu_s), 32'(v.op));
            if (c == 1)            check("inbus_a", 32'(o_alu_inbus), 32'(v.a));
            else if (c == 2)       check("inbus_b", 32'(o_alu_inbus), 32'(v.b));
            else if (c <= 2 + wc)  check("inbus_wait", 32'(o_alu_inbus), 32'd0);
            check("rsp_valid", 32'(o_rsp_valid), 32'(c >= rc));
            if (c >= rc) begin
                check("rsp_data",  32'(o_rsp_data),  32'(v.exp_data));
                check("rsp_flags", 32'(o_rsp_flags), 32'(v.exp_flags));
                check("rsp_err",   32'(o_rsp_err),   32'(v.exp_err));
            end
            in_wait    = (c >= 3) && (c <= 2 + wc);
            cmd_valid  = 1'($urandom);
            cmd_op     = 4'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
            alu_finish = in_wait ? (v.k > 0 && c == v.k + 2) : 1'($urandom);
            alu_flg    = (in_wait && c == v.k + 2) ? v.flg : 4'($urandom);
            alu_outbus = (fin && c == v.k + 3) ? v.outv : 16'($urandom);
            rsp_ready  = (c < rc) ? 1'($urandom) : (c == last);
        end
        @(negedge clk);
        check("rsp_valid_done", 32'(o_rsp_valid), 32'd0);
        check("cmd_ready_done", 32'(o_cmd_ready), 32'd1);
        cmd_valid = 1'b0; rsp_ready = 1'b0; alu_finish = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        tbl[0] = mk(4'h0, 16'h0003, 16'h0004, 4, 16'h0007, 4'b0000, 0,  1'b0, 16'h0007, 4'b0000, 1'b0);
        tbl[1] = mk(4'h1, 16'h1234, 16'h1234, 2, 16'h0000, 4'b0110, 0,  1'b0, 16'h0000, 4'b0110, 1'b0);
        tbl[2] = mk(4'h2, 16'hA5A5, 16'h5A5A, 0, 16'h1111, 4'b1111, 2,  1'b0, 16'h0000, 4'b0000, 1'b1);
        tbl[3] = mk(4'h3, 16'h8000, 16'h8000, 1, 16'h8001, 4'b1011, 10, 1'b0, 16'h8001, 4'b1011, 1'b0);
        tbl[4] = mk(4'hF, 16'hFFFF, 16'h0001, 8, 16'h4242, 4'b0101, 0,  1'b0, 16'h4242, 4'b0101, 1'b0);
        tbl[5] = mk(4'hC, 16'h0F0F, 16'hF0F0, 9, 16'h9999, 4'b1100, 1,  1'b0, 16'h0000, 4'b0000, 1'b1);
        tbl[6] = mk(4'h6, 16'h0102, 16'h0304, 4, 16'hBEEF, 4'b1001, 0,  1'b1, 16'hBEEF, 4'b1001, 1'b0);
        tbl[7] = mk(4'h7, 16'h0001, 16'h0002, 5, 16'h7777, 4'b1111, 0,  1'b1, 16'h0000, 4'b0000, 1'b1);
        tbl[8] = mk(4'h8, 16'h2468, 16'h1357, 3, 16'h1357, 4'b0010, 1,  1'b1, 16'h1357, 4'b0010, 1'b0);

        #3 do_reset();

        foreach (tbl[i]) begin
            if (tbl[i].use4 != use4) begin
                use4 = tbl[i].use4;
                do_reset();
            end
            run_txn(tbl[i]);
        end

        use4 = 1'b0;
        do_reset();

        // Reset while waiting on the ALU: the command vanishes without a response.
        run_txn(mk(4'h9, 16'h1111, 16'h2222, 1, 16'h5A5A, 4'b1010, 0, 1'b0, 16'h5A5A, 4'b1010, 1'b0));
        cmd_valid = 1'b1; cmd_op = 4'h5; cmd_a = 16'hAAAA; cmd_b = 16'h5555;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_b = 1'b0;
        #1 check_reset_outputs("mid_wait_async");
        @(negedge clk);
        check_reset_outputs("mid_wait_held");
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_finish = 1'(i == 1);
            @(negedge clk);
            check("post_reset_no_rsp", 32'(o_rsp_valid), 32'd0);
            check("post_reset_ready", 32'(o_cmd_ready), 32'd1);
        end
        alu_finish = 1'b0;
        run_txn(mk(4'h0, 16'h00FF, 16'h0001, 3, 16'h0100, 4'b0000, 0, 1'b0, 16'h0100, 4'b0000, 1'b0));

        for (int i = 0; i < 40; i++) begin
            v = mk(4'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 10)),
                   16'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b0,
                   16'h0, 4'h0, 1'b0);
            run_txn(model(v));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_host.md
ALU_HOST -- requirements
Module: alu_host

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: maximum WAIT cycles before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_b  input  1  reset; asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request from client.
REQ-005 cmd_ready  output  1  module can accept a command; high only in IDLE.
REQ-006 cmd_op  input  4  ALU operation code, forwarded unmodified.
REQ-007 cmd_a, cmd_b  input  16 each  first and second operands.
REQ-008 rsp_valid  output  1  response available.
REQ-009 rsp_ready  input  1  client accepts response.
REQ-010 rsp_data  output  16  captured result word.
REQ-011 rsp_flags  output  4  captured {negative, zero, carry, overflow}.
REQ-012 rsp_err  output  1  response produced by timeout, not by ALU completion.
REQ-013 alu_start  output  1  one-cycle start pulse to ALU.
REQ-014 alu_s  output  4  operation select to ALU.
REQ-015 alu_inbus  output  16  operand bus to ALU.
REQ-016 alu_outbus  input  16  registered ALU result bus.
REQ-017 alu_negative, alu_zero, alu_carry, alu_overflow  input  1 each  ALU status flags.
REQ-018 alu_finish  input  1  ALU completion pulse.

Function
REQ-019 States SHALL be IDLE, START, OPB, WAIT, CAPT, RESP; one-hot or binary encoding is free.
REQ-020 IDLE: cmd_ready=1; on cmd_valid=1, SHALL latch cmd_op, cmd_a, cmd_b into internal registers and go to START.
REQ-021 START (1 cycle): alu_start=1, alu_s=latched op, alu_inbus=latched A; next state OPB.
REQ-022 OPB (1 cycle): alu_start=0, alu_inbus=latched B; next state WAIT.
REQ-023 WAIT: alu_inbus=0; alu_s SHALL stay at latched op from START until return to IDLE.
REQ-024 WAIT: on alu_finish=1, SHALL latch the four flags in that same cycle and go to CAPT.
REQ-025 CAPT (1 cycle): SHALL latch alu_outbus into rsp_data (ALU output is registered, valid one cycle after finish); rsp_err=0; next state RESP.
REQ-026 WAIT: 8-bit timeout counter cleared on entering WAIT, +1 per WAIT cycle without finish; when count reaches TIMEOUT_CYC-1 with no finish, next state RESP with rsp_data=0, rsp_flags=0, rsp_err=1.
REQ-027 alu_finish and timeout in the same cycle: finish wins (normal completion).
REQ-028 RESP: rsp_valid=1, rsp_data/flags/err stable; on rsp_ready=1 go to IDLE; rsp_valid holds indefinitely otherwise.
REQ-029 alu_finish outside WAIT SHALL be ignored (no state or output change).
REQ-030 cmd_valid outside IDLE SHALL be ignored; command fields need not be held after acceptance.
REQ-031 Latency cmd accept -> rsp_valid = 3 + N cycles, N = WAIT cycles until finish (finish seen in first WAIT cycle gives rsp_valid 4 cycles after accept edge).
REQ-032 Back-to-back: rsp_ready in RESP and cmd_valid high in following IDLE cycle SHALL start next command with no extra bubble.
REQ-033 All outputs SHALL be registered or decoded from the state register only; no combinational path from alu_* inputs to any output.

Reset
REQ-034 rst_b=0 SHALL immediately force IDLE, counter=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, alu_start=0, alu_s=0, alu_inbus=0.
REQ-035 Reset mid-operation (any state) SHALL discard the command without a response; first command after release starts clean.

Verification
REQ-036 Add: op=0000, A=0x0003, B=0x0004, ALU finish 5 cycles after start, outbus=0x0007 -> alu_start one cycle with inbus=0x0003, next cycle 0x0004; rsp_data=0x0007, flags=0000, err=0.
REQ-037 Sub to zero: A=B=0x1234, ALU flags zero=1, carry=1 at finish, outbus=0x0000 -> rsp_flags=0110, rsp_data=0x0000.
REQ-038 Timeout: TIMEOUT_CYC=8, ALU never finishes -> rsp_valid after exactly 8 WAIT cycles, rsp_err=1, rsp_data=0x0000; late alu_finish afterwards ignored.
REQ-039 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and data stable, cmd_ready=0, new cmd_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-040 Reset in WAIT: rst_b low for 1 cycle -> all outputs at REQ-034 values asynchronously; no rsp_valid; next command A=0x00FF, B=0x0001 completes normally.
REQ-041 Finish on timeout boundary: TIMEOUT_CYC=4, finish on 4th WAIT cycle -> err=0, rsp_data from outbus one cycle later.
